// File: rtl/debug_frame_tx_pkg.sv
// Shared definitions for the debug snapshot serialiser: byte width, default
// sync byte and the 2-bit FSM state encoding.
package debug_frame_tx_pkg;

  localparam int NB_DATA_8 = 8;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } frame_state_e;

endpackage

// File: rtl/debug_frame_tx.sv
// Serialises a wide pipeline debug snapshot into SYNC, payload (MS byte first)
// and XOR checksum bytes, handing them to uart_tx one at a time.
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int                  NB_DATA   = NB_DATA_8,
  parameter int                  NB_FRAME  = 256,
  parameter logic [NB_DATA-1:0]  SYNC_BYTE = NB_DATA'(SYNC_BYTE_DEFAULT)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_send,
  input  logic [NB_FRAME-1:0] i_frame,
  input  logic                i_tx_done,
  output logic                o_tx_start,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [1:0]          o_dbg_state
);

  localparam int NBYTES = NB_FRAME / NB_DATA;
  localparam int IDX_W  = $clog2(NBYTES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBYTES + 1);
  localparam logic [IDX_W-1:0] NBYTES_IDX = IDX_W'(NBYTES);

  if ((NB_FRAME % NB_DATA) != 0) begin : g_bad_frame_width
    $error("debug_frame_tx: NB_FRAME must be a multiple of NB_DATA");
  end

  // Handshake with uart_tx: o_tx_start is a one-cycle pulse launching o_data;
  // o_data then holds until uart_tx answers with a one-cycle i_tx_done, which
  // is only honoured in WAIT. i_send is only honoured in IDLE and never queued.

  frame_state_e            state, state_next;
  logic [NB_FRAME-1:0]     shadow;
  logic [IDX_W-1:0]        idx;
  logic [NB_DATA-1:0]      chk;
  logic [NB_DATA-1:0]      next_byte;

  assign next_byte = shadow[NB_FRAME-1 -: NB_DATA];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_send) state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          state_next = (idx == LAST_IDX) ? ST_DONE : ST_SEND;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_tx_start   = (state == ST_SEND);
  assign o_busy       = (state == ST_SEND) || (state == ST_WAIT);
  assign o_frame_done = (state == ST_DONE);
  assign o_dbg_state  = state;

  // o_data only moves on the edge that enters SEND, so it is stable for uart_tx
  // across the whole start/done window.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow <= '0;
      idx    <= '0;
      chk    <= '0;
      o_data <= '0;
    end else if ((state == ST_IDLE) && i_send) begin
      shadow <= i_frame;
      idx    <= '0;
      chk    <= '0;
      o_data <= SYNC_BYTE;
    end else if ((state == ST_WAIT) && i_tx_done && (idx != LAST_IDX)) begin
      idx <= idx + 1'b1;
      if (idx < NBYTES_IDX) begin
        o_data <= next_byte;
        shadow <= shadow << NB_DATA;
        chk    <= chk ^ next_byte;
      end else begin
        o_data <= chk;
      end
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx with a 32-bit snapshot and a uart_tx
// model that answers each o_tx_start after a programmable delay.
module tb_debug_frame_tx;
  import debug_frame_tx_pkg::*;

  localparam int NB_DATA  = 8;
  localparam int NB_FRAME = 32;

  // clock / reset and DUT signals
  logic                clk = 1'b0;
  logic                i_rst_n;
  logic                i_send;
  logic [NB_FRAME-1:0] i_frame;
  logic                i_tx_done;
  logic                model_done = 1'b0;
  logic                extra_done;
  logic                o_tx_start;
  logic [NB_DATA-1:0]  o_data;
  logic                o_busy;
  logic                o_frame_done;
  logic [1:0]          o_dbg_state;

  always #5 clk = ~clk;

  assign i_tx_done = model_done | extra_done;

  debug_frame_tx #(
    .NB_DATA  (NB_DATA),
    .NB_FRAME (NB_FRAME)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_send       (i_send),
    .i_frame      (i_frame),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_dbg_state  (o_dbg_state)
  );

  // scoreboard state
  logic [NB_DATA-1:0] exp_q[$];
  logic [NB_DATA-1:0] cur_byte;
  int checks = 0;
  int errors = 0;
  int tx_delay = 2;
  int pend_cnt = 0;
  bit pending = 0;
  int bytes_done = 0;
  int frame_done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: latches the byte on o_tx_start, checks it against the
  // expected queue, checks it stays stable, then pulses i_tx_done.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      pending    = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (pending) begin
        check("data_stable", o_data, cur_byte);
        pend_cnt--;
        if (pend_cnt == 0) begin
          model_done = 1'b1;
          pending    = 0;
          bytes_done++;
        end
      end
      if (o_tx_start) begin
        cur_byte = o_data;
        check("start_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_byte", o_data, exp_q.pop_front());
        pending  = 1;
        pend_cnt = tx_delay;
      end
      if (o_frame_done) frame_done_cnt++;
    end
  end

  // driver tasks
  task automatic push6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
    exp_q.push_back(b5);
  endtask

  task automatic send_pulse(input logic [NB_FRAME-1:0] f);
    @(posedge clk); #1;
    i_frame = f;
    i_send  = 1'b1;
    @(posedge clk); #1;
    i_send  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (o_frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, (n < budget), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_start"},   o_tx_start,   0);
    check({tag, "_busy"},       o_busy,       0);
    check({tag, "_frame_done"}, o_frame_done, 0);
    check({tag, "_state"},      o_dbg_state,  ST_IDLE);
  endtask

  int fd0;
  int b0;
  int n;
  int delays[2] = '{1, 1000};

  initial begin
    i_rst_n    = 1'b0;
    i_send     = 1'b0;
    i_frame    = '0;
    extra_done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_data", o_data, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;

    // 1: basic frame 11223344, checksum 44
    tx_delay = 3;
    push6(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    fd0 = frame_done_cnt;
    send_pulse(32'h1122_3344);
    @(negedge clk);
    check("t1_start_latency", o_tx_start, 1);
    check("t1_busy", o_busy, 1);
    wait_done("t1", 200);
    @(negedge clk);
    check_idle_outputs("t1_after");
    check("t1_frame_count", frame_done_cnt - fd0, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: i_frame change and i_send pulse mid-frame are ignored
    tx_delay = 2;
    push6(8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    fd0 = frame_done_cnt;
    send_pulse(32'hFF00_0000);
    repeat (8) @(posedge clk);
    #1;
    i_frame = 32'h1234_5678;
    i_send  = 1'b1;
    @(posedge clk); #1;
    i_send  = 1'b0;
    wait_done("t2", 200);
    repeat (20) @(negedge clk);
    check("t2_frame_count", frame_done_cnt - fd0, 1);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_busy", o_busy, 0);

    // 3: reset right after the second byte completes
    tx_delay = 2;
    push6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hDE);
    fd0 = frame_done_cnt;
    b0  = bytes_done;
    send_pulse(32'hDEAD_BEEF);
    n = 0;
    while (bytes_done != b0 + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t3_two_bytes_seen", (n < 100), 1);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("t3_rst");
    check("t3_rst_data", o_data, 0);
    repeat (2) @(negedge clk);
    check("t3_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    check("t3_no_frame_done", frame_done_cnt - fd0, 0);
    push6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    send_pulse(32'h0102_0304);
    @(negedge clk);
    check("t3_restart_byte", o_data, 8'hA5);
    wait_done("t3", 200);
    @(negedge clk);
    check("t3_frame_count", frame_done_cnt - fd0, 1);
    check("t3_queue_empty_after", exp_q.size(), 0);

    // 4: same frame with fast and slow uart_tx
    foreach (delays[k]) begin
      tx_delay = delays[k];
      push6(8'hA5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04);
      fd0 = frame_done_cnt;
      send_pulse(32'hA1B2_C3D4);
      wait_done("t4", 8000);
      @(negedge clk);
      check("t4_frame_count", frame_done_cnt - fd0, 1);
      check("t4_queue_empty", exp_q.size(), 0);
    end

    // 5: stray i_tx_done while idle
    repeat (4) begin
      @(posedge clk); #1;
      extra_done = 1'b1;
      @(negedge clk);
      check_idle_outputs("t5");
      @(posedge clk); #1;
      extra_done = 1'b0;
    end

    // 6: i_send held high gives back-to-back frames
    tx_delay = 1;
    push6(8'hA5, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00);
    push6(8'hA5, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00);
    fd0 = frame_done_cnt;
    @(posedge clk); #1;
    i_frame = 32'h0F0F_0F0F;
    i_send  = 1'b1;
    wait_done("t6a", 200);
    @(negedge clk);
    check("t6_gap_busy", o_busy, 0);
    check("t6_gap_state", o_dbg_state, ST_IDLE);
    @(negedge clk);
    check("t6_restart", o_tx_start, 1);
    @(posedge clk); #1;
    i_send = 1'b0;
    wait_done("t6b", 200);
    repeat (20) @(negedge clk);
    check("t6_frame_count", frame_done_cnt - fd0, 2);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
